// File: rtl/keypad_scan_fifo_if.sv
// keypad_scan_fifo_if: key-event FIFO port toward the CPU,
// valid/ready pop plus fill level and sticky overflow.
interface keypad_scan_fifo_if #(
   parameter int ROWS  = 4,
   parameter int COLS  = 4,
   parameter int DEPTH = 4
) ();
   localparam int KW = $clog2(ROWS * COLS);
   localparam int CW = $clog2(DEPTH) + 1;

   logic          out_valid;
   logic [KW-1:0] out_code;
   logic          out_ready;
   logic [CW-1:0] fifo_count;
   logic          overflow;
   logic          clr_ovf;

   modport master (
      output out_valid,
      output out_code,
      output fifo_count,
      output overflow,
      input  out_ready,
      input  clr_ovf
   );

   modport slave (
      input  out_valid,
      input  out_code,
      input  fifo_count,
      input  overflow,
      output out_ready,
      output clr_ovf
   );
endinterface

// File: rtl/keypad_scan_fifo.sv
// keypad_scan_fifo: matrix keypad scanner with debounce,
// key encoding and a first-word-fall-through event FIFO.
module keypad_scan_fifo #(
   parameter int ROWS     = 4,
   parameter int COLS     = 4,
   parameter int SCAN_DIV = 100000,
   parameter int DEBOUNCE = 8,
   parameter int DEPTH    = 4,
   localparam int KW      = $clog2(ROWS * COLS)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [ROWS-1:0] row,
   output logic [COLS-1:0] col,
   output logic            key_down,
   output logic [KW-1:0]   key_cur,
   keypad_scan_fifo_if.master bus
);
   localparam int DW  = $clog2(SCAN_DIV);
   localparam int CIW = $clog2(COLS);
   localparam int RW  = $clog2(ROWS);
   localparam int DBW = $clog2(DEBOUNCE + 1);
   localparam int AW  = $clog2(DEPTH);
   localparam int PW  = AW + 1;

   typedef enum logic [1:0] {IDLE, SCAN, DEB, HOLD} state_t;

   state_t          state_q;
   logic [DW-1:0]   div_q;
   logic [ROWS-1:0] sync1_q;
   logic [ROWS-1:0] rs_q;
   logic [ROWS-1:0] pat_q;
   logic [CIW-1:0]  c_q;
   logic [DBW-1:0]  dcnt_q;
   logic [DBW-1:0]  qcnt_q;
   logic [COLS-1:0] col_q;
   logic            key_down_q;
   logic [KW-1:0]   key_cur_q;

   logic            tick;
   logic            all1;
   logic            deb_last;
   logic            quiet_last;
   logic            push;
   logic [RW-1:0]   row_idx;
   logic [KW-1:0]   code;

   assign tick       = (div_q == DW'(SCAN_DIV - 1));
   assign all1       = &rs_q;
   assign deb_last   = (int'(dcnt_q) + 1 >= DEBOUNCE);
   assign quiet_last = (int'(qcnt_q) + 1 >= DEBOUNCE);
   assign push       = tick && (state_q == DEB) &&
                       (rs_q == pat_q) && deb_last;

   // Lowest-index low row wins when several rows are pulled.
   always_comb begin
      row_idx = '0;
      for (int i = ROWS - 1; i >= 0; i--) begin
         if (!rs_q[i]) row_idx = RW'(i);
      end
   end

   assign code = KW'(int'(row_idx) * COLS + int'(c_q));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q   <= '0;
         sync1_q <= '1;
         rs_q    <= '1;
      end else begin
         div_q   <= tick ? '0 : div_q + 1'b1;
         sync1_q <= row;
         rs_q    <= sync1_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         c_q        <= '0;
         pat_q      <= '1;
         dcnt_q     <= '0;
         qcnt_q     <= '0;
         col_q      <= '0;
         key_down_q <= 1'b0;
         key_cur_q  <= '0;
      end else if (tick) begin
         unique case (state_q)
            IDLE: begin
               if (!all1) begin
                  c_q     <= '0;
                  col_q   <= ~(COLS'(1));
                  state_q <= SCAN;
               end
            end
            SCAN: begin
               if (!all1) begin
                  pat_q   <= rs_q;
                  dcnt_q  <= DBW'(1);
                  state_q <= DEB;
               end else if (c_q == CIW'(COLS - 1)) begin
                  col_q   <= '0;
                  state_q <= IDLE;
               end else begin
                  c_q   <= c_q + 1'b1;
                  col_q <= ~(COLS'(1) << (c_q + 1'b1));
               end
            end
            DEB: begin
               if (rs_q != pat_q) begin
                  col_q   <= '0;
                  state_q <= IDLE;
               end else if (deb_last) begin
                  key_down_q <= 1'b1;
                  key_cur_q  <= code;
                  qcnt_q     <= '0;
                  state_q    <= HOLD;
               end else begin
                  dcnt_q <= dcnt_q + 1'b1;
               end
            end
            HOLD: begin
               if (!all1) begin
                  qcnt_q <= '0;
               end else if (quiet_last) begin
                  key_down_q <= 1'b0;
                  col_q      <= '0;
                  state_q    <= IDLE;
               end else begin
                  qcnt_q <= qcnt_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign col      = col_q;
   assign key_down = key_down_q;
   assign key_cur  = key_cur_q;

   logic [KW-1:0] mem_q [DEPTH];
   logic [PW-1:0] wptr_q;
   logic [PW-1:0] rptr_q;
   logic          ovf_q;
   logic          ovf_d;
   logic [PW-1:0] count;
   logic          full;
   logic          empty;
   logic          pop;
   logic          wr;
   logic          ovf_set;

   assign count   = wptr_q - rptr_q;
   assign full    = (count == PW'(DEPTH));
   assign empty   = (count == '0);
   assign pop     = !empty && bus.out_ready;
   // A pop in the same cycle frees the slot, so a full push still lands.
   assign wr      = push && (!full || pop);
   assign ovf_set = push && full && !pop;
   assign ovf_d   = ovf_set || (ovf_q && !bus.clr_ovf);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
         ovf_q  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         ovf_q <= ovf_d;
         if (pop) rptr_q <= rptr_q + 1'b1;
         if (wr) begin
            mem_q[wptr_q[AW-1:0]] <= code;
            wptr_q                <= wptr_q + 1'b1;
         end
      end
   end

   assign bus.out_valid  = !empty;
   assign bus.out_code   = empty ? '0 : mem_q[rptr_q[AW-1:0]];
   assign bus.fifo_count = count;
   assign bus.overflow   = ovf_q;
endmodule
